// File: rtl/exec_pkg.sv
// Execute-stage shared definitions: flag indices, NOP opcode,
// flag vector type and save-stack state encoding.
package exec_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;

  localparam int NF_DEF = 3;
  localparam logic [4:0] NOP_OPCODE = 5'b01010;

  typedef logic [NF_DEF-1:0] flags_t;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_PARTIAL,
    ST_FULL
  } lifo_state_t;

endpackage

// File: rtl/flag_stack_register_if.sv
// Bundle of control inputs and flag/stack status outputs
// between the execute stage and the flag register.
interface flag_stack_register_if #(
  parameter int NF  = 3,
  parameter int OPW = 5,
  parameter int CW  = 3
);

  logic           en;
  logic [OPW-1:0] opcode;
  logic [NF-1:0]  in_flags;
  logic [NF-1:0]  upd_mask;
  logic [NF-1:0]  set_mask;
  logic [NF-1:0]  clr_mask;
  logic           push;
  logic           pop;
  logic [NF-1:0]  out_flags;
  logic [CW-1:0]  depth;
  logic           full;
  logic           empty;
  logic           err;

  modport master (
    output en, opcode, in_flags,
    output upd_mask, set_mask, clr_mask,
    output push, pop,
    input  out_flags, depth,
    input  full, empty, err
  );

  modport slave (
    input  en, opcode, in_flags,
    input  upd_mask, set_mask, clr_mask,
    input  push, pop,
    output out_flags, depth,
    output full, empty, err
  );

endinterface

// File: rtl/flag_lifo.sv
// Flag save stack: DEPTH x NF storage, depth counter FSM,
// legal push/pop decode and sticky misuse indicator.
module flag_lifo
  import exec_pkg::*;
#(
  parameter int NF    = 3,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [NF-1:0] wdata,
  output logic [NF-1:0] rdata,
  output logic          pop_ok,
  output logic [CW-1:0] depth,
  output logic          full,
  output logic          empty,
  output logic          err
);

  lifo_state_t   state_q, state_d;
  logic [CW-1:0] depth_q, depth_d;
  logic          err_q, err_d;
  logic          push_ok;
  logic [NF-1:0] mem [DEPTH];

  assign depth = depth_q;
  assign full  = (depth_q == CW'(DEPTH));
  assign empty = (depth_q == '0);
  assign err   = err_q;

  always_comb begin
    depth_d = depth_q;
    err_d   = err_q;
    push_ok = 1'b0;
    pop_ok  = 1'b0;
    unique case (1'b1)
      push && pop: err_d = 1'b1;
      push && !pop: begin
        if (state_q == ST_FULL) begin
          err_d = 1'b1;
        end else begin
          push_ok = 1'b1;
          depth_d = depth_q + CW'(1);
        end
      end
      pop && !push: begin
        if (state_q == ST_EMPTY) begin
          err_d = 1'b1;
        end else begin
          pop_ok  = 1'b1;
          depth_d = depth_q - CW'(1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = ST_PARTIAL;
    if (depth_d == '0)
      state_d = ST_EMPTY;
    else if (depth_d == CW'(DEPTH))
      state_d = ST_FULL;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_EMPTY;
      depth_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      depth_q <= depth_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (push_ok && depth_q == CW'(i))
          mem[i] <= wdata;
    end
  end

  // top-of-stack is the entry just below depth
  always_comb begin
    rdata = '0;
    for (int i = 0; i < DEPTH; i++)
      if (depth_q == CW'(i + 1))
        rdata = mem[i];
  end

endmodule

// File: rtl/flag_stack_register.sv
// Execute-stage condition-code register with masked update,
// NOP suppression and an interrupt save/restore stack.
module flag_stack_register
  import exec_pkg::*;
#(
  parameter int             NF     = 3,
  parameter int             DEPTH  = 4,
  parameter int             OPW    = 5,
  parameter logic [OPW-1:0] NOP_OP = OPW'(NOP_OPCODE),
  parameter int             CW     = $clog2(DEPTH+1)
) (
  input  logic clk,
  input  logic rst,
  flag_stack_register_if.slave bus
);

  logic [NF-1:0] flags_q;
  logic [NF-1:0] flags_d;
  logic [NF-1:0] upd_flags;
  logic [NF-1:0] stk_rdata;
  logic          valid;
  logic          pop_ok;

  assign valid = bus.en && (bus.opcode != NOP_OP);

  // clear is applied last so it wins over set
  always_comb begin
    upd_flags = flags_q;
    if (valid) begin
      upd_flags = (flags_q & ~bus.upd_mask)
                | (bus.in_flags & bus.upd_mask);
      upd_flags = upd_flags | bus.set_mask;
      upd_flags = upd_flags & ~bus.clr_mask;
    end
  end

  always_comb begin
    flags_d = upd_flags;
    if (pop_ok)
      flags_d = stk_rdata;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      flags_q <= '0;
    else
      flags_q <= flags_d;
  end

  assign bus.out_flags = flags_q;

  flag_lifo #(
    .NF    (NF),
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_lifo (
    .clk    (clk),
    .rst    (rst),
    .push   (bus.push),
    .pop    (bus.pop),
    .wdata  (flags_q),
    .rdata  (stk_rdata),
    .pop_ok (pop_ok),
    .depth  (bus.depth),
    .full   (bus.full),
    .empty  (bus.empty),
    .err    (bus.err)
  );

endmodule

// File: tb/tb_flag_stack_register.sv
// Scoreboard bench for flag_stack_register with directed
// vectors and hand-computed expectations.
module tb_flag_stack_register;
  import exec_pkg::*;

  typedef struct {
    string      name;
    logic [2:0] flags;
    logic [2:0] depth;
    logic       full;
    logic       empty;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  flag_stack_register_if #(.NF(3), .OPW(5), .CW(3)) bus ();

  flag_stack_register #(
    .NF(3), .DEPTH(4), .OPW(5),
    .NOP_OP(5'b01010), .CW(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic exp_t mk(input string n,
      input logic [2:0] f, input logic [2:0] d,
      input logic fu, input logic em, input logic er);
    exp_t e;
    e.name = n; e.flags = f; e.depth = d;
    e.full = fu; e.empty = em; e.err = er;
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checks++;
      if (bus.out_flags !== e.flags || bus.depth !== e.depth ||
          bus.full !== e.full || bus.empty !== e.empty ||
          bus.err !== e.err) begin
        failures++;
        $display("FAIL %s: got flags=%b depth=%0d full=%b empty=%b err=%b want flags=%b depth=%0d full=%b empty=%b err=%b",
          e.name, bus.out_flags, bus.depth, bus.full, bus.empty,
          bus.err, e.flags, e.depth, e.full, e.empty, e.err);
      end
    end
  end

  task automatic idle();
    bus.en = 1'b0; bus.opcode = 5'b0;
    bus.in_flags = 3'b0; bus.upd_mask = 3'b0;
    bus.set_mask = 3'b0; bus.clr_mask = 3'b0;
    bus.push = 1'b0; bus.pop = 1'b0;
  endtask

  task automatic step(input logic e, input logic [4:0] op,
      input logic [2:0] inf, input logic [2:0] upd,
      input logic [2:0] set, input logic [2:0] clr,
      input logic ps, input logic pp, input exp_t x);
    @(negedge clk);
    bus.en = e; bus.opcode = op; bus.in_flags = inf;
    bus.upd_mask = upd; bus.set_mask = set; bus.clr_mask = clr;
    bus.push = ps; bus.pop = pp;
    @(posedge clk);
    #1 sb.push_back(x);
  endtask

  task automatic do_reset(input string n);
    @(negedge clk);
    idle();
    rst = 1'b0;
    #1 sb.push_back(mk(n, 3'b000, 3'd0, 1'b0, 1'b1, 1'b0));
    @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    sb.push_back(mk("reset", 3'b000, 3'd0, 1'b0, 1'b1, 1'b0));

    step(1, 5'b00001, 3'b111, 3'b101, 3'b000, 3'b000, 0, 0,
         mk("upd_mask", 3'b101, 3'd0, 0, 1, 0));
    step(1, 5'b01010, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0,
         mk("nop_hold", 3'b101, 3'd0, 0, 1, 0));
    step(0, 5'b00001, 3'b000, 3'b111, 3'b111, 3'b000, 0, 0,
         mk("en_low_hold", 3'b101, 3'd0, 0, 1, 0));
    step(1, 5'b00001, 3'b000, 3'b111, 3'b000, 3'b000, 0, 0,
         mk("clear_all", 3'b000, 3'd0, 0, 1, 0));
    step(1, 5'b00001, 3'b000, 3'b000, 3'b110, 3'b010, 0, 0,
         mk("set_clr_prio", 3'b100, 3'd0, 0, 1, 0));
    step(1, 5'b00001, 3'b011, 3'b111, 3'b000, 3'b000, 0, 0,
         mk("load_011", 3'b011, 3'd0, 0, 1, 0));
    step(1, 5'b00001, 3'b100, 3'b111, 3'b000, 3'b000, 1, 0,
         mk("push_upd", 3'b100, 3'd1, 0, 0, 0));
    step(1, 5'b00001, 3'b111, 3'b111, 3'b000, 3'b000, 0, 1,
         mk("pop_restore", 3'b011, 3'd0, 0, 1, 0));
    step(0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1,
         mk("pop_empty_err", 3'b011, 3'd0, 0, 1, 1));

    do_reset("reset_clears_err");
    step(1, 5'b00001, 3'b001, 3'b111, 3'b000, 3'b000, 1, 0,
         mk("ovf_push1", 3'b001, 3'd1, 0, 0, 0));
    step(1, 5'b00001, 3'b010, 3'b111, 3'b000, 3'b000, 1, 0,
         mk("ovf_push2", 3'b010, 3'd2, 0, 0, 0));
    step(1, 5'b00001, 3'b011, 3'b111, 3'b000, 3'b000, 1, 0,
         mk("ovf_push3", 3'b011, 3'd3, 0, 0, 0));
    step(1, 5'b00001, 3'b100, 3'b111, 3'b000, 3'b000, 1, 0,
         mk("ovf_push4_full", 3'b100, 3'd4, 1, 0, 0));
    step(1, 5'b00001, 3'b101, 3'b111, 3'b000, 3'b000, 1, 0,
         mk("ovf_push5_err", 3'b101, 3'd4, 1, 0, 1));
    step(0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1,
         mk("ovf_pop1", 3'b011, 3'd3, 0, 0, 1));
    step(0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1,
         mk("ovf_pop2", 3'b010, 3'd2, 0, 0, 1));
    step(0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1,
         mk("ovf_pop3", 3'b001, 3'd1, 0, 0, 1));
    step(0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1,
         mk("ovf_pop4", 3'b000, 3'd0, 0, 1, 1));

    do_reset("reset_before_unf");
    step(1, 5'b00001, 3'b110, 3'b111, 3'b000, 3'b000, 0, 1,
         mk("underflow", 3'b110, 3'd0, 0, 1, 1));

    do_reset("reset_before_conf");
    step(1, 5'b00001, 3'b001, 3'b111, 3'b000, 3'b000, 1, 1,
         mk("conflict_empty", 3'b001, 3'd0, 0, 1, 1));
    step(1, 5'b00001, 3'b010, 3'b111, 3'b000, 3'b000, 1, 0,
         mk("conf_push", 3'b010, 3'd1, 0, 0, 1));
    step(1, 5'b00001, 3'b100, 3'b111, 3'b000, 3'b000, 1, 1,
         mk("conflict_d1", 3'b100, 3'd1, 0, 0, 1));
    step(0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 0, 1,
         mk("conf_pop", 3'b001, 3'd0, 0, 1, 1));

    do_reset("reset_before_async");
    step(0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0,
         mk("as_push1", 3'b000, 3'd1, 0, 0, 0));
    step(0, 5'b00000, 3'b000, 3'b000, 3'b000, 3'b000, 1, 0,
         mk("as_push2", 3'b000, 3'd2, 0, 0, 0));
    step(1, 5'b00001, 3'b101, 3'b111, 3'b000, 3'b000, 1, 0,
         mk("as_push3", 3'b101, 3'd3, 0, 0, 0));
    @(negedge clk);
    bus.en = 1'b1; bus.opcode = 5'b00001;
    bus.in_flags = 3'b010; bus.upd_mask = 3'b111;
    bus.push = 1'b0; bus.pop = 1'b1;
    @(posedge clk);
    #2 rst = 1'b0;
    sb.push_back(mk("async_reset", 3'b000, 3'd0, 0, 1, 0));
    @(negedge clk);
    idle();
    rst = 1'b1;
    step(1, 5'b00001, 3'b011, 3'b111, 3'b000, 3'b000, 0, 0,
         mk("post_reset_upd", 3'b011, 3'd0, 0, 1, 0));

    @(negedge clk);
    idle();
    for (int i = 0; i < 10 && sb.size() > 0; i++)
      @(negedge clk);
    if (sb.size() > 0) begin
      failures++;
      $display("FAIL drain: %0d entries left, want 0", sb.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/flag_stack_register.md
# flag_stack_register

Parametrised condition-code register for the execute stage. Holds NF flags with per-flag selective update from the ALU and explicit set/clear masks, and suppresses updates for NOP opcodes. Adds a DEPTH-entry save/restore stack so flags are preserved across interrupt entry (push) and restored on return (pop). Its output feeds branch resolution and the ALU carry-in.

## Interface
Parameters:
- NF, 3, number of flags; bit 0 = Z, bit 1 = N, bit 2 = C, higher bits free for extension.
- DEPTH, 4, save-stack entries; must be ≥ 1.
- OPW, 5, opcode width.
- NOP_OP, 5'b01010, opcode value that suppresses flag updates.
- CW, $clog2(DEPTH+1), width of the depth counter.

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- rst, in, 1, reset; asynchronous, active-low.
- en, in, 1, flag-write enable from the decode/control path.
- opcode, in, OPW, opcode of the instruction in execute.
- in_flags, in, NF, flags produced by the ALU this cycle.
- upd_mask, in, NF, per-flag select; 1 = take the in_flags bit.
- set_mask, in, NF, per-flag force-to-1 (SETC-style instructions).
- clr_mask, in, NF, per-flag force-to-0 (CLRC-style instructions).
- push, in, 1, save the current flags (interrupt entry).
- pop, in, 1, restore flags from the stack (RTI).
- out_flags, out, NF, current flags.
- depth, out, CW, number of valid stack entries.
- full, out, 1, depth == DEPTH.
- empty, out, 1, depth == 0.
- err, out, 1, sticky overflow/underflow/conflict indicator.

## Operation
- Definition: valid = en && (opcode != NOP_OP).
- Normal update, applied when valid and no pop takes effect, evaluated in this order:
  - start from out_flags;
  - bits selected by upd_mask take in_flags;
  - set_mask bits become 1;
  - clr_mask bits become 0. clr wins over set.
- When valid = 0, out_flags holds; set_mask, clr_mask and upd_mask are ignored.
- push with !full and !pop:
  - stack[depth] ← out_flags as it stands before this edge's update;
  - depth increments;
  - the normal update still applies in the same cycle.
- pop with !empty and !push:
  - out_flags ← stack[depth-1];
  - depth decrements;
  - the normal update is discarded that cycle.
- push while full: nothing stored, depth unchanged, err ← 1, normal update applies.
- pop while empty: depth unchanged, err ← 1, normal update applies.
- push and pop in the same cycle: stack and depth unchanged, err ← 1, normal update applies.
- err is sticky; only rst clears it.
- The state machine is the depth counter, with states EMPTY (0), PARTIAL (1..DEPTH-1) and FULL (DEPTH). Transitions occur only via a legal push or pop.

## Timing
- Reset (rst = 0, asynchronous): out_flags = 0, depth = 0, empty = 1, full = 0, err = 0. Stack contents are don't-care.
- After rst deasserts, the first rising edge performs a normal update.
- Latency: every input effect is visible on out_flags one rising edge later. There is no combinational path from inputs to out_flags.
- full, empty and depth are decoded from registered depth only, so they are valid in the same cycle as depth.
- Reset asserted mid-operation (a push or pop pending) discards that operation entirely.
- Wrap-around: none. depth saturates at 0 and DEPTH, with err reporting the attempted overflow or underflow.

## Structure
- Shared package (exec_pkg): flag index constants FLAG_Z = 0, FLAG_N = 1, FLAG_C = 2; the default NOP opcode constant; a flag-vector typedef sized by NF.
- One sub-module, flag_lifo: a DEPTH×NF storage array plus the depth counter with push/pop/full/empty/err logic. The top level holds the out_flags register and the mask/priority logic.

## Test plan
- Reset state: hold rst = 0, then release → out_flags = 000, depth = 0, empty = 1, err = 0.
- Masked update and NOP suppression:
  - en = 1, opcode = 00001, in_flags = 111, upd_mask = 101 → out_flags = 101;
  - next, opcode = 01010, in_flags = 000, upd_mask = 111 → out_flags stays 101.
- Set/clear priority: out_flags = 000, set_mask = 110, clr_mask = 010, upd_mask = 000 → out_flags = 100.
- Interrupt round-trip:
  - out_flags = 011; push together with an update of in_flags = 100, upd_mask = 111 → out_flags = 100, depth = 1;
  - next, pop → out_flags = 011, depth = 0, empty = 1.
- Overflow, underflow and conflict (DEPTH = 4):
  - five pushes → depth = 4, full = 1, err = 1 after the fifth;
  - after reset, pop → err = 1, depth = 0;
  - after reset, push and pop together → err = 1, depth unchanged.
- Asynchronous reset mid-stack: depth = 3, flags = 101; drop rst between clock edges → all outputs reach reset values immediately, without waiting for a clock edge.
